// File: rtl/ip1_scan_out_capture.sv
// rtl/ip1_scan_out_capture.sv - ASIC scan-chain readback capture FSM (optional parity via IP1_SCAN_OUT_PARITY_EN)
module ip1_scan_out_capture (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [6:0]  clk_counter,
  input  logic [6:0]  test_delay,
  input  logic        start_re,
  input  logic        scan_out_i,
  input  logic [12:0] shift_cnt_max,
  output logic [2:0]  sm_state,
  output logic        o_scan_load,
  output logic        o_capture_bit,
  output logic        o_capture_valid,
  output logic [12:0] o_shift_cnt,
  output logic        o_busy,
  output logic        o_status_done,
  output logic        o_parity
);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_DELAY     = 3'd1;
  localparam logic [2:0] ST_LOAD      = 3'd2;
  localparam logic [2:0] ST_SHIFT_OUT = 3'd3;
  localparam logic [2:0] ST_DONE      = 3'd4;

  logic [2:0]  state;
  logic        scan_load;
  logic        capture_bit;
  logic        capture_valid;
  logic [12:0] shift_cnt;
  logic        status_done;
  logic        boundary;
  logic [12:0] shift_cnt_next;
  logic        block_clear;
  logic        start_accept;
  logic        capture_en;

  assign boundary     = (test_delay == clk_counter);
  assign block_clear  = reset || !enable;
  assign start_accept = (state == ST_IDLE) && start_re;
  assign capture_en   = (state == ST_SHIFT_OUT) && boundary;

  // Saturate rather than wrap so a shrunken shift_cnt_max can never alias back to a match.
  assign shift_cnt_next = (shift_cnt == 13'h1fff) ? shift_cnt : shift_cnt + 13'd1;

  always_ff @(posedge clk) begin
    if (block_clear) begin
      state         <= ST_IDLE;
      scan_load     <= 1'b1;
      capture_bit   <= 1'b0;
      capture_valid <= 1'b0;
      shift_cnt     <= 13'd0;
      status_done   <= 1'b0;
    end else begin
      capture_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          scan_load <= 1'b1;
          if (start_re) begin
            state       <= ST_DELAY;
            status_done <= 1'b0;
            shift_cnt   <= 13'd0;
          end
        end
        ST_DELAY: begin
          if (boundary) begin
            state     <= ST_LOAD;
            scan_load <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (boundary) begin
            if (shift_cnt_max != 13'd0) begin
              state     <= ST_SHIFT_OUT;
              scan_load <= 1'b0;
            end else begin
              state       <= ST_DONE;
              scan_load   <= 1'b1;
              status_done <= 1'b1;
            end
          end
        end
        ST_SHIFT_OUT: begin
          if (boundary) begin
            capture_bit   <= scan_out_i;
            capture_valid <= 1'b1;
            shift_cnt     <= shift_cnt_next;
            if (shift_cnt_next == shift_cnt_max) begin
              state       <= ST_DONE;
              scan_load   <= 1'b1;
              status_done <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          status_done <= 1'b1;
          scan_load   <= 1'b1;
          state       <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef IP1_SCAN_OUT_PARITY_EN
  logic parity;

  always_ff @(posedge clk) begin
    if (block_clear || start_accept) begin
      parity <= 1'b0;
    end else if (capture_en) begin
      parity <= parity ^ scan_out_i;
    end
  end

  assign o_parity = parity;
`else
  assign o_parity = 1'b0;
`endif

  assign sm_state        = state;
  assign o_scan_load     = scan_load;
  assign o_capture_bit   = capture_bit;
  assign o_capture_valid = capture_valid;
  assign o_shift_cnt     = shift_cnt;
  assign o_busy          = (state != ST_IDLE);
  assign o_status_done   = status_done;

endmodule
